// File: rtl/matrix_led_pwm_driver.sv
// rtl/matrix_led_pwm_driver.sv - row-scanned LED matrix driver with double-buffered greyscale PWM
module matrix_led_pwm_driver #(
   parameter int ROWS         = 8,
   parameter int COLS         = 8,
   parameter int BPP          = 4,
   parameter int STEP_CYCLES  = 1600,
   parameter int BLANK_CYCLES = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [$clog2(ROWS)-1:0]  wr_row,
   input  logic [COLS*BPP-1:0]      wr_data,
   input  logic                     swap_req,
   output logic                     swap_pending,
   output logic                     frame_start,
   output logic [ROWS-1:0]          row,
   output logic [COLS-1:0]          col
);

   localparam int RW   = $clog2(ROWS);
   localparam int CMAX = (BLANK_CYCLES > STEP_CYCLES) ? BLANK_CYCLES : STEP_CYCLES;
   localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
   localparam logic [CW-1:0]  BLANK_LAST = CW'(BLANK_CYCLES - 1);
   localparam logic [CW-1:0]  STEP_LAST  = CW'(STEP_CYCLES - 1);
   localparam logic [BPP-1:0] STEP_MAX   = BPP'((1 << BPP) - 2);
   localparam logic [RW-1:0]  ROW_LAST   = RW'(ROWS - 1);
   localparam logic [RW:0]    ROWS_LIM   = (RW+1)'(ROWS);

   typedef enum logic {S_BLANK, S_PWM} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cyc, cyc_nxt;
   logic [BPP-1:0]  step, step_nxt;
   logic [RW-1:0]   r, r_nxt;
   logic            wrap, wrap_d, load_shadow;
   logic            front, front_eff, swap_now, wr_ok;
   logic [COLS*BPP-1:0] pix_buf [0:1][0:ROWS-1];
   logic [COLS*BPP-1:0] shadow;
   logic [ROWS-1:0] row_d;
   logic [COLS-1:0] col_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_BLANK;
         cyc   <= '0;
         step  <= '0;
         r     <= '0;
      end else begin
         state <= state_nxt;
         cyc   <= cyc_nxt;
         step  <= step_nxt;
         r     <= r_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cyc_nxt     = cyc;
      step_nxt    = step;
      r_nxt       = r;
      wrap        = 1'b0;
      load_shadow = 1'b0;
      case (state)
         S_BLANK: begin
            if (cyc == BLANK_LAST) begin
               load_shadow = 1'b1;
               state_nxt   = S_PWM;
               cyc_nxt     = '0;
               step_nxt    = '0;
            end else begin
               cyc_nxt = cyc + 1'b1;
            end
         end
         S_PWM: begin
            if (cyc == STEP_LAST) begin
               cyc_nxt = '0;
               if (step == STEP_MAX) begin
                  state_nxt = S_BLANK;
                  wrap      = (r == ROW_LAST);
                  r_nxt     = (r == ROW_LAST) ? '0 : r + 1'b1;
               end else begin
                  step_nxt = step + 1'b1;
               end
            end else begin
               cyc_nxt = cyc + 1'b1;
            end
         end
         default: state_nxt = S_BLANK;
      endcase
   end

   // Outputs lag the sequencer by one cycle; the swap lands on the edge that starts the visible frame.
   assign swap_now  = wrap_d & swap_pending;
   assign front_eff = front ^ swap_now;
   assign wr_ok     = wr_en && ({1'b0, wr_row} < ROWS_LIM);

   always_comb begin
      row_d = '0;
      col_d = '0;
      if (state == S_PWM) begin
         row_d = ROWS'(1) << r;
         for (int c = 0; c < COLS; c++) begin
            col_d[c] = shadow[c*BPP +: BPP] > step;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         front        <= 1'b0;
         swap_pending <= 1'b0;
         frame_start  <= 1'b0;
         wrap_d       <= 1'b0;
         shadow       <= '0;
         row          <= '0;
         col          <= '0;
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < ROWS; i++) begin
               pix_buf[b][i] <= '0;
            end
         end
      end else begin
         wrap_d      <= wrap;
         frame_start <= wrap_d;
         if (swap_now) begin
            front        <= ~front;
            swap_pending <= 1'b0;
         end else if (swap_req) begin
            swap_pending <= 1'b1;
         end
         if (wr_ok) begin
            pix_buf[~front][wr_row] <= wr_data;
         end
         if (load_shadow) begin
            shadow <= pix_buf[front_eff][r];
         end
         row <= row_d;
         col <= col_d;
      end
   end

endmodule

// File: tb/tb_matrix_led_pwm_driver.sv
// tb/tb_matrix_led_pwm_driver.sv - randomized self-checking bench with a frame-arithmetic reference model
module tb_matrix_led_pwm_driver;

   localparam int ROWS  = 4;
   localparam int COLS  = 4;
   localparam int BPP   = 2;
   localparam int STEP  = 4;
   localparam int BLANK = 2;
   localparam int SLOT  = BLANK + ((1 << BPP) - 1) * STEP;
   localparam int FRAME = ROWS * SLOT;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             wr_en = 1'b0;
   logic [1:0]       wr_row = '0;
   logic [7:0]       wr_data = '0;
   logic             swap_req = 1'b0;
   logic             swap_pending, frame_start;
   logic [ROWS-1:0]  row;
   logic [COLS-1:0]  col;

   matrix_led_pwm_driver #(
      .ROWS(ROWS), .COLS(COLS), .BPP(BPP), .STEP_CYCLES(STEP), .BLANK_CYCLES(BLANK)
   ) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
      .swap_req(swap_req), .swap_pending(swap_pending), .frame_start(frame_start),
      .row(row), .col(col)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: position in the frame is plain arithmetic on edges since reset release.
   bit started = 1'b0;
   int k = 0;
   int mfront = 0;
   bit mpend = 1'b0;
   int mbuf [2][ROWS];

   always @(posedge clk) begin
      int p;
      bit bnd;
      if (reset) begin
         started = 1'b1;
         k = 0;
         mfront = 0;
         mpend = 1'b0;
         for (int b = 0; b < 2; b++)
            for (int i = 0; i < ROWS; i++)
               mbuf[b][i] = 0;
      end else if (started) begin
         k++;
         p = (k - 1) % FRAME;
         bnd = (p == 0) && (k > 1);
         if (wr_en && wr_row < ROWS) mbuf[1 - mfront][wr_row] = wr_data;
         if (bnd && mpend) begin
            mfront = 1 - mfront;
            mpend = 1'b0;
         end else if (swap_req) begin
            mpend = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      int p, slot, off, s, pix;
      logic [ROWS-1:0] er;
      logic [COLS-1:0] ec;
      logic efs;
      if (started) begin
         er = '0;
         ec = '0;
         efs = 1'b0;
         if (k > 0) begin
            p = (k - 1) % FRAME;
            slot = p / SLOT;
            off = p % SLOT;
            efs = (p == 0) && (k > 1);
            if (off >= BLANK) begin
               er = ROWS'(1) << slot;
               s = (off - BLANK) / STEP;
               for (int c = 0; c < COLS; c++) begin
                  pix = (mbuf[mfront][slot] >> (c * BPP)) & ((1 << BPP) - 1);
                  if (pix > s) ec[c] = 1'b1;
               end
            end
         end
         check("row", row, er);
         check("col", col, ec);
         check("frame_start", frame_start, efs);
         check("swap_pending", swap_pending, mpend);
      end
   end

   task automatic drive(input bit we, input int rw, input int d, input bit sw);
      wr_en = we;
      wr_row = rw[1:0];
      wr_data = d[7:0];
      swap_req = sw;
      @(negedge clk);
      wr_en = 1'b0;
      swap_req = 1'b0;
   endtask

   task automatic wait_frame();
      bit found = 1'b0;
      for (int i = 0; i < FRAME + 8 && !found; i++) begin
         @(negedge clk);
         if (frame_start === 1'b1) found = 1'b1;
      end
      check("frame_start_timeout", found, 1'b1);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // idle scan after reset
      @(negedge clk);
      check("s1_dark_row", row, 4'b0000);
      check("s1_dark_col", col, 4'b0000);
      repeat (2) @(negedge clk);
      check("s1_row0_lit", row, 4'b0001);
      check("s1_row0_col", col, 4'b0000);
      repeat (12) @(negedge clk);
      check("s1_blank_before_row1", row, 4'b0000);
      repeat (2) @(negedge clk);
      check("s1_row1_lit", row, 4'b0010);
      wait_frame();
      repeat (3) @(negedge clk);

      // gradient on row 0
      drive(1'b1, 0, 8'hE4, 1'b1);
      check("s2_pending_set", swap_pending, 1'b1);
      wait_frame();
      check("s2_pending_clear", swap_pending, 1'b0);
      repeat (2) @(negedge clk);
      check("s2_step0_col", col, 4'b1110);
      check("s2_step0_row", row, 4'b0001);
      repeat (4) @(negedge clk);
      check("s2_step1_col", col, 4'b1100);
      repeat (4) @(negedge clk);
      check("s2_step2_col", col, 4'b1000);
      repeat (6) @(negedge clk);
      check("s2_row1_row", row, 4'b0010);
      check("s2_row1_col", col, 4'b0000);

      // back-buffer writes without swap
      for (int i = 1; i < ROWS; i++) drive(1'b1, i, $urandom, 1'b0);
      repeat (3 * FRAME) @(negedge clk);
      check("s3_no_pending", swap_pending, 1'b0);

      // double request, then request in the boundary cycle
      repeat (5) @(negedge clk);
      drive(1'b0, 0, 0, 1'b1);
      repeat (10) @(negedge clk);
      drive(1'b0, 0, 0, 1'b1);
      wait_frame();
      check("s4_single_swap", swap_pending, 1'b0);
      wait_frame();
      drive(1'b0, 0, 0, 1'b1);
      check("s4_boundary_req_pending", swap_pending, 1'b1);
      wait_frame();
      check("s4_boundary_req_swapped", swap_pending, 1'b0);

      // reset in the middle of row 2
      repeat (33) @(negedge clk);
      check("s5_row2_lit", row, 4'b0100);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("s5_reset_row", row, 4'b0000);
      check("s5_reset_col", col, 4'b0000);
      repeat (5) @(negedge clk);
      drive(1'b0, 0, 0, 1'b1);
      wait_frame();

      // full brightness everywhere
      for (int i = 0; i < ROWS; i++) drive(1'b1, i, 8'hFF, 1'b0);
      drive(1'b0, 0, 0, 1'b1);
      wait_frame();
      @(negedge clk);
      check("s6_dark_row", row, 4'b0000);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check("s6_full_col", col, 4'b1111);
      end
      @(negedge clk);
      check("s6_gap1", row, 4'b0000);
      @(negedge clk);
      check("s6_gap2", col, 4'b0000);
      @(negedge clk);
      check("s6_row1_full", {row, col}, 8'b0010_1111);

      // randomized traffic
      for (int i = 0; i < 2500; i++) begin
         wr_en = ($urandom % 3) == 0;
         wr_row = 2'($urandom);
         wr_data = 8'($urandom);
         swap_req = ($urandom % 40) == 0;
         reset = ($urandom % 700) == 0;
         @(negedge clk);
      end
      wr_en = 1'b0;
      swap_req = 1'b0;
      reset = 1'b0;
      repeat (4) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
